// File: rtl/vram_arbiter.sv
// Fixed-priority (display > clear > draw) arbiter for a single-port video SRAM with a vblank-paced frame-clear engine.
// Reads return 2 edges after sampling; display is never stalled, clear yields to display, draw waits for both.
module vram_arbiter #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 8,
    parameter int FB_WORDS = 30000
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_valid,
    input  logic              draw_req,
    input  logic              draw_we,
    input  logic [ADDR_W-1:0] draw_addr,
    input  logic [DATA_W-1:0] draw_wdata,
    output logic              draw_ack,
    output logic [DATA_W-1:0] draw_rdata,
    output logic              draw_rvalid,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_colour,
    input  logic              vblank,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_FILL = 1'b1;

    localparam logic [1:0] T_NONE = 2'd0;
    localparam logic [1:0] T_DISP = 2'd1;
    localparam logic [1:0] T_DRAW = 2'd2;
    localparam logic [1:0] T_ZERO = 2'd3;

    localparam logic [ADDR_W-1:0] FB_END  = ADDR_W'(FB_WORDS);
    localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(FB_WORDS - 1);

    logic [0:0]        clr_state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] clr_col;
    logic [1:0]        tag_q1;
    logic [1:0]        tag_q2;

    logic clr_wr;
    logic grant_draw;
    logic draw_in_range;

    assign clr_busy = (clr_state == S_FILL);

    // draw_ack blocks a regrant while the client has not yet seen its ack
    always_comb begin
        clr_wr        = 1'b0;
        grant_draw    = 1'b0;
        draw_in_range = 1'b0;
        clr_wr        = clr_busy && vblank && !disp_req;
        grant_draw    = draw_req && !disp_req && !clr_busy && !clr_start && !draw_ack;
        draw_in_range = (draw_addr < FB_END);
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            draw_ack  <= 1'b0;
            tag_q1    <= T_NONE;
        end else begin
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            tag_q1   <= T_NONE;
            draw_ack <= grant_draw;
            if (disp_req) begin
                mem_en   <= 1'b1;
                mem_addr <= disp_addr;
                tag_q1   <= T_DISP;
            end else if (clr_wr) begin
                mem_en    <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= clr_cnt;
                mem_wdata <= clr_col;
            end else if (grant_draw) begin
                // out-of-range draws are acked but never reach the SRAM
                if (draw_in_range) begin
                    mem_en   <= 1'b1;
                    mem_we   <= draw_we;
                    mem_addr <= draw_addr;
                    if (draw_we) begin
                        mem_wdata <= draw_wdata;
                    end
                end
                if (!draw_we) begin
                    tag_q1 <= draw_in_range ? T_DRAW : T_ZERO;
                end
            end
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            clr_state <= S_IDLE;
            clr_cnt   <= '0;
            clr_col   <= '0;
            clr_done  <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (clr_state)
                S_IDLE: begin
                    if (clr_start) begin
                        clr_col   <= clr_colour;
                        clr_cnt   <= '0;
                        clr_state <= S_FILL;
                    end
                end
                default: begin
                    if (clr_wr) begin
                        if (clr_cnt == FB_LAST) begin
                            clr_state <= S_IDLE;
                            clr_done  <= 1'b1;
                        end else begin
                            clr_cnt <= clr_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            tag_q2      <= T_NONE;
            disp_valid  <= 1'b0;
            disp_rdata  <= '0;
            draw_rvalid <= 1'b0;
            draw_rdata  <= '0;
        end else begin
            tag_q2      <= tag_q1;
            disp_valid  <= (tag_q2 == T_DISP);
            draw_rvalid <= tag_q2[1];
            if (tag_q2 == T_DISP) begin
                disp_rdata <= mem_rdata;
            end
            if (tag_q2 == T_DRAW) begin
                draw_rdata <= mem_rdata;
            end else if (tag_q2 == T_ZERO) begin
                draw_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: vector table for arbitration/latency, sequences for reset, clear and draw hold-off.
module tb_vram_arbiter;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        disp_req = 1'b0;
    logic [14:0] disp_addr = '0;
    logic [7:0]  disp_rdata;
    logic        disp_valid;
    logic        draw_req = 1'b0;
    logic        draw_we = 1'b0;
    logic [14:0] draw_addr = '0;
    logic [7:0]  draw_wdata = '0;
    logic        draw_ack;
    logic [7:0]  draw_rdata;
    logic        draw_rvalid;
    logic        clr_start = 1'b0;
    logic [7:0]  clr_colour = '0;
    logic        vblank = 1'b0;
    logic        clr_busy;
    logic        clr_done;
    logic        mem_en;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;

    vram_arbiter #(.ADDR_W(15), .DATA_W(8), .FB_WORDS(30000)) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_rdata(disp_rdata), .disp_valid(disp_valid),
        .draw_req(draw_req), .draw_we(draw_we), .draw_addr(draw_addr), .draw_wdata(draw_wdata),
        .draw_ack(draw_ack), .draw_rdata(draw_rdata), .draw_rvalid(draw_rvalid),
        .clr_start(clr_start), .clr_colour(clr_colour), .vblank(vblank),
        .clr_busy(clr_busy), .clr_done(clr_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #10 CLOCK = ~CLOCK;

    // SRAM model: registered read data, valid the cycle after the access edge
    logic [7:0] mem_model [0:32767];
    logic       preload_en = 1'b0;
    always @(posedge CLOCK) begin
        if (preload_en) begin
            mem_model[15'h0010] <= 8'hA5;
            mem_model[15'h0011] <= 8'h5B;
        end else if (mem_en) begin
            if (mem_we) mem_model[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem_model[mem_addr];
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    // Clear-phase monitor: sampled inputs of the previous edge vs. mem_* after it
    logic s_vblank = 1'b0, s_disp = 1'b0, s_busy = 1'b0;
    int   cyc_cnt = 0;
    always @(posedge CLOCK) begin
        s_vblank <= vblank;
        s_disp   <= disp_req;
        s_busy   <= clr_busy;
        cyc_cnt  <= cyc_cnt + 1;
    end

    logic mon_on = 1'b0;
    int   wr_cnt = 0, bad_cnt = 0, exp_addr = 0;
    int   done_cnt = 0, done_cyc = 0, ack_cnt = 0, ack_cyc = 0;
    always @(negedge CLOCK) begin
        if (mon_on) begin
            if (s_busy) begin
                if (mem_en && mem_we) begin
                    wr_cnt++;
                    if (!(s_vblank && !s_disp) || mem_addr != exp_addr[14:0] || mem_wdata != 8'h07)
                        bad_cnt++;
                    exp_addr++;
                end else if (s_vblank && !s_disp) begin
                    bad_cnt++;
                end
                if (s_disp && !(mem_en && !mem_we)) bad_cnt++;
            end else if (mem_en && mem_we && mem_addr != 15'h0100) begin
                bad_cnt++;
            end
            if (clr_done) begin
                done_cnt++;
                done_cyc = cyc_cnt;
            end
            if (draw_ack) begin
                ack_cnt++;
                ack_cyc = cyc_cnt;
            end
        end
    end

    typedef struct {
        logic        dq;  logic [14:0] da;
        logic        rq;  logic        rwe; logic [14:0] ra; logic [7:0] rwd;
        logic        en;  logic        we;  logic [14:0] addr; logic [7:0] wd;
        logic        ack; logic        dv;  logic [7:0] dd;
        logic        rv;  logic [7:0]  rd;
    } vec_t;

    vec_t vecs [0:21];

    initial begin
        //          dq da       rq rwe ra        rwd    | en we addr     wd     ack dv dd     rv rd
        vecs[0]  = '{1, 15'h10, 0, 0, 15'h0,    8'h00,  1, 0, 15'h10, 8'h00, 0, 0, 8'h00, 0, 8'h00};
        vecs[1]  = '{0, 15'h0,  0, 0, 15'h0,    8'h00,  0, 0, 15'h10, 8'h00, 0, 0, 8'h00, 0, 8'h00};
        vecs[2]  = '{0, 15'h0,  0, 0, 15'h0,    8'h00,  0, 0, 15'h10, 8'h00, 0, 1, 8'hA5, 0, 8'h00};
        vecs[3]  = '{0, 15'h0,  0, 0, 15'h0,    8'h00,  0, 0, 15'h10, 8'h00, 0, 0, 8'h00, 0, 8'h00};
        vecs[4]  = '{1, 15'h11, 1, 1, 15'h20,   8'h3C,  1, 0, 15'h11, 8'h00, 0, 0, 8'h00, 0, 8'h00};
        vecs[5]  = '{0, 15'h0,  1, 1, 15'h20,   8'h3C,  1, 1, 15'h20, 8'h3C, 1, 0, 8'h00, 0, 8'h00};
        vecs[6]  = '{0, 15'h0,  1, 1, 15'h20,   8'h3C,  0, 0, 15'h20, 8'h00, 0, 1, 8'h5B, 0, 8'h00};
        vecs[7]  = '{0, 15'h0,  0, 0, 15'h0,    8'h00,  0, 0, 15'h20, 8'h00, 0, 0, 8'h00, 0, 8'h00};
        vecs[8]  = '{0, 15'h0,  1, 0, 15'h20,   8'h00,  1, 0, 15'h20, 8'h00, 1, 0, 8'h00, 0, 8'h00};
        vecs[9]  = '{0, 15'h0,  0, 0, 15'h0,    8'h00,  0, 0, 15'h20, 8'h00, 0, 0, 8'h00, 0, 8'h00};
        vecs[10] = '{0, 15'h0,  0, 0, 15'h0,    8'h00,  0, 0, 15'h20, 8'h00, 0, 0, 8'h00, 1, 8'h3C};
        vecs[11] = '{0, 15'h0,  1, 1, 15'd30000, 8'hFF, 0, 0, 15'h20, 8'h00, 1, 0, 8'h00, 0, 8'h00};
        vecs[12] = '{0, 15'h0,  0, 0, 15'h0,    8'h00,  0, 0, 15'h20, 8'h00, 0, 0, 8'h00, 0, 8'h00};
        vecs[13] = '{0, 15'h0,  1, 0, 15'd30005, 8'h00, 0, 0, 15'h20, 8'h00, 1, 0, 8'h00, 0, 8'h00};
        vecs[14] = '{0, 15'h0,  0, 0, 15'h0,    8'h00,  0, 0, 15'h20, 8'h00, 0, 0, 8'h00, 0, 8'h00};
        vecs[15] = '{0, 15'h0,  0, 0, 15'h0,    8'h00,  0, 0, 15'h20, 8'h00, 0, 0, 8'h00, 1, 8'h00};
        vecs[16] = '{1, 15'h10, 1, 0, 15'h20,   8'h00,  1, 0, 15'h10, 8'h00, 0, 0, 8'h00, 0, 8'h00};
        vecs[17] = '{0, 15'h0,  1, 0, 15'h20,   8'h00,  1, 0, 15'h20, 8'h00, 1, 0, 8'h00, 0, 8'h00};
        vecs[18] = '{0, 15'h0,  1, 0, 15'h20,   8'h00,  0, 0, 15'h20, 8'h00, 0, 1, 8'hA5, 0, 8'h00};
        vecs[19] = '{0, 15'h0,  0, 0, 15'h0,    8'h00,  0, 0, 15'h20, 8'h00, 0, 0, 8'h00, 1, 8'h3C};
        vecs[20] = '{0, 15'h0,  1, 1, 15'h7FFF, 8'h11,  0, 0, 15'h20, 8'h00, 1, 0, 8'h00, 0, 8'h00};
        vecs[21] = '{0, 15'h0,  0, 0, 15'h0,    8'h00,  0, 0, 15'h20, 8'h00, 0, 0, 8'h00, 0, 8'h00};

        // Power-on reset: every output low
        preload_en = 1'b1;
        #5;
        chk("por_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 64'd0);
        chk("por_rd", {disp_valid, disp_rdata, draw_ack, draw_rvalid, draw_rdata, clr_busy, clr_done}, 64'd0);
        tick();
        preload_en = 1'b0;
        #8 RESET = 1'b0;

        // Arbitration, latency and range handling
        for (int i = 0; i < 22; i++) begin
            disp_req = vecs[i].dq;  disp_addr = vecs[i].da;
            draw_req = vecs[i].rq;  draw_we = vecs[i].rwe;
            draw_addr = vecs[i].ra; draw_wdata = vecs[i].rwd;
            tick();
            chk($sformatf("v%0d_en", i),   mem_en,      vecs[i].en);
            chk($sformatf("v%0d_we", i),   mem_we,      vecs[i].we);
            chk($sformatf("v%0d_addr", i), mem_addr,    vecs[i].addr);
            chk($sformatf("v%0d_ack", i),  draw_ack,    vecs[i].ack);
            chk($sformatf("v%0d_dv", i),   disp_valid,  vecs[i].dv);
            chk($sformatf("v%0d_rv", i),   draw_rvalid, vecs[i].rv);
            if (vecs[i].we) chk($sformatf("v%0d_wd", i), mem_wdata,  vecs[i].wd);
            if (vecs[i].dv) chk($sformatf("v%0d_dd", i), disp_rdata, vecs[i].dd);
            if (vecs[i].rv) chk($sformatf("v%0d_rd", i), draw_rdata, vecs[i].rd);
        end
        disp_req = 1'b0; draw_req = 1'b0; draw_we = 1'b0;

        // Reset in the middle of a fill (counter at 100), then restart from 0
        begin
            bit hit = 1'b0;
            clr_start = 1'b1; clr_colour = 8'h33; vblank = 1'b1;
            tick();
            clr_start = 1'b0;
            for (int c = 0; c < 300 && !hit; c++) begin
                tick();
                if (mem_en && mem_we && mem_addr == 15'd99) hit = 1'b1;
            end
            chk("rst_reach_cnt100", hit, 1'b1);
        end
        #4 RESET = 1'b1;
        #1;
        chk("rst_busy", clr_busy, 1'b0);
        chk("rst_mem", {mem_en, mem_we, mem_addr, mem_wdata}, 64'd0);
        chk("rst_rd", {disp_valid, disp_rdata, draw_ack, draw_rvalid, draw_rdata, clr_done}, 64'd0);
        tick();
        #8 RESET = 1'b0;
        tick();
        chk("rst_idle_no_write", {clr_busy, mem_en}, 64'd0);
        clr_start = 1'b1; clr_colour = 8'h44;
        tick();
        clr_start = 1'b0;
        chk("restart_busy", {clr_busy, mem_en}, 64'h2);
        tick();
        chk("restart_first_write", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 15'd0, 8'h44});
        #4 RESET = 1'b1;
        tick();
        #8 RESET = 1'b0;
        vblank = 1'b0;

        // Full clear with vblank gating and display traffic; draw write held from the start
        begin
            bit stop_disp = 1'b0;
            mon_on = 1'b1;
            clr_start = 1'b1; clr_colour = 8'h07;
            draw_req = 1'b1; draw_we = 1'b1; draw_addr = 15'h0100; draw_wdata = 8'h5A;
            disp_addr = 15'h0010;
            for (int c = 0; c < 60000 && !(done_cnt > 0 && ack_cnt > 0); c++) begin
                vblank   = (c < 3000) ? ((c % 30) < 10) : 1'b1;
                disp_req = stop_disp ? 1'b0 : ((c % 4) == 0);
                tick();
                clr_start = 1'b0;
                if (clr_done) stop_disp = 1'b1;
                if (draw_ack) draw_req = 1'b0;
            end
            disp_req = 1'b0; draw_req = 1'b0;
            tick();
            tick();
            mon_on = 1'b0;
        end
        chk("clr_write_count", wr_cnt, 30000);
        chk("clr_bad_writes", bad_cnt, 0);
        chk("clr_done_count", done_cnt, 1);
        chk("clr_busy_after", clr_busy, 1'b0);
        chk("holdoff_ack_count", ack_cnt, 1);
        chk("holdoff_ack_cycle", ack_cyc, done_cyc + 1);
        chk("mem_first", mem_model[0], 8'h07);
        chk("mem_last", mem_model[29999], 8'h07);
        chk("mem_draw_landed", mem_model[256], 8'h5A);

        // Read back the held draw write through the draw port
        draw_req = 1'b1; draw_we = 1'b0; draw_addr = 15'h0100;
        tick();
        chk("rb_ack", draw_ack, 1'b1);
        draw_req = 1'b0;
        tick();
        chk("rb_rvalid_early", draw_rvalid, 1'b0);
        tick();
        chk("rb_rvalid", draw_rvalid, 1'b1);
        chk("rb_rdata", draw_rdata, 8'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port video SRAM (1-cycle read latency) among three requesters: display pixel fetch, a frame-clear engine, and the drawing client.
- Sits between the pixel-fetch logic driven by the 800x600@72Hz sync generator (50 MHz) and the frame-buffer SRAM.
- Fixed priority: display > clear > draw. Display fetches are never delayed.

Parameters:
- ADDR_W, 15, SRAM address width
- DATA_W, 8, pixel word width (one stored pixel per word)
- FB_WORDS, 30000, frame-buffer words (200x150 stored pixels, each shown as 4x4)

Ports:
- CLOCK  in  1  system clock, 50 MHz
- RESET  in  1  asynchronous, active-high reset
- disp_req  in  1  display read request, single-cycle pulse, at most 1 per 4 cycles
- disp_addr  in  ADDR_W  display read address
- disp_rdata  out  DATA_W  display read data
- disp_valid  out  1  disp_rdata valid, 1-cycle pulse
- draw_req  in  1  draw request, held until draw_ack
- draw_we  in  1  1 = write, 0 = read
- draw_addr  in  ADDR_W  draw address
- draw_wdata  in  DATA_W  draw write data
- draw_ack  out  1  request accepted, 1-cycle pulse
- draw_rdata  out  DATA_W  draw read data
- draw_rvalid  out  1  draw_rdata valid, 1-cycle pulse
- clr_start  in  1  start frame clear, pulse
- clr_colour  in  DATA_W  fill colour, sampled with clr_start
- vblank  in  1  vertical blanking active (from sync timing)
- clr_busy  out  1  clear in progress
- clr_done  out  1  clear finished, 1-cycle pulse
- mem_en  out  1  SRAM access enable
- mem_we  out  1  SRAM write enable
- mem_addr  out  ADDR_W  SRAM address
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data, valid the cycle after the SRAM samples a read

Behaviour:
- Reset (async):
  - All outputs 0.
  - Clear FSM goes to IDLE; fill counter cleared.
  - In-flight read tags discarded; no disp_valid or draw_rvalid issued after reset.
- Arbitration and timing:
  - Arbitration runs every clock on requests sampled at edge N; the winner drives the registered mem_* outputs after edge N.
  - The SRAM samples the access at edge N+1.
  - Read data is registered into disp_rdata or draw_rdata at edge N+2, with the matching valid high for exactly one cycle.
  - Read latency is fixed: 2 edges from request sampling to valid.
- No access granted: mem_en = 0 and mem_we = 0. mem_addr and mem_wdata hold their last values.
- Display path:
  - disp_req is always granted in the cycle it is sampled.
  - Lower-priority requesters stall that cycle.
- Draw path:
  - Granted only when disp_req = 0, clr_busy = 0 and clr_start = 0.
  - draw_ack pulses 1 cycle after the grant edge. The client must drop or change its request the cycle after draw_ack.
  - A write with draw_addr >= FB_WORDS is acked with mem_en = 0 (dropped).
  - A read with draw_addr >= FB_WORDS is acked and returns draw_rdata = 0, with draw_rvalid at normal latency.
- Clear FSM:
  - IDLE: clr_start latches clr_colour, fill counter := 0, clr_busy := 1, go to FILL. clr_start is ignored outside IDLE.
  - FILL: each cycle with vblank = 1 and disp_req = 0, write clr_colour to address = counter and increment counter.
    - vblank = 0 pauses the fill (no write); it resumes at the next vblank at the same counter.
    - After the write to FB_WORDS-1: clr_busy := 0, clr_done pulses 1 cycle, go to IDLE.
  - Draw requests are held off for the whole time clr_busy = 1, so the clear is never partially overwritten.
- Simultaneous events:
  - clr_start and draw_req in the same cycle: clear wins; draw waits.
  - disp_req during a clear write cycle: display wins and the counter does not advance.
- Counters are unsigned, ADDR_W wide, and never wrap past FB_WORDS-1.

Test Plan:
- Reset state: RESET high mid-fill at counter 100 -> next edge clr_busy = 0, all outputs 0; after release the FSM is IDLE and a new clr_start restarts at address 0.
- Display read: disp_req with disp_addr = 0x0010, SRAM preloaded with 0xA5 at that address -> disp_valid = 1 exactly 2 edges later, disp_rdata = 0xA5.
- Priority: disp_req and draw_req (write 0x3C to 0x0020) in the same cycle -> display granted first; draw_ack arrives one cycle later; then a read of 0x0020 returns 0x3C.
- Clear paused by vblank: clr_start with colour 0x07, vblank toggling (10 on / 20 off), disp_req every 4th cycle -> writes only while vblank = 1 and disp_req = 0, addresses strictly sequential 0..29999, exactly one clr_done, clr_busy low afterwards.
- Draw hold-off: draw_req held while clr_busy = 1 -> no draw_ack until the cycle after clr_done; the write then lands and the read-back is correct.
- Out-of-range: draw write to 30000 -> ack with no mem_en; draw read at 30005 -> draw_rvalid with draw_rdata = 0.
